// File: rtl/tdm_link_scheduler_pkg.sv
// Shared definitions for the TDM link scheduler: FSM state encoding and a
// binary-to-Gray helper used by the Gray-coded counters in the NoC.
package tdm_link_scheduler_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } sched_state_t;

    // Wide enough for any slot or pointer counter in the NoC; callers zero-extend.
    localparam int GRAY_W = 8;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/tdm_link_scheduler_slot.sv
// Slot timer for the TDM scheduler: counts SLOT_LEN cycles per slot and rotates
// the slot index mod N_REQ, exporting it in binary and registered Gray code.
module tdm_slot_timer
    import tdm_link_scheduler_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int SLOT_LEN = 4,
    parameter int SW       = $clog2(N_REQ)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [SW-1:0] slot,
    output logic [SW-1:0] slot_gray
);

    localparam int TW = $clog2(SLOT_LEN);

    logic [TW-1:0]     timer_q, timer_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [SW-1:0]     slot_gray_q, slot_gray_d;
    logic [GRAY_W-1:0] gray_full;

    always_comb begin
        timer_d = timer_q;
        slot_d  = slot_q;
        if (en) begin
            if (timer_q == TW'(SLOT_LEN - 1)) begin
                timer_d = '0;
                // N_REQ is a power of two, so natural overflow is the mod-N wrap.
                slot_d  = slot_q + SW'(1);
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // Gray code is taken from the next slot value so the output stays registered.
    always_comb begin
        gray_full   = bin2gray(GRAY_W'(slot_d));
        slot_gray_d = gray_full[SW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q     <= '0;
            slot_q      <= '0;
            slot_gray_q <= '0;
        end else begin
            timer_q     <= timer_d;
            slot_q      <= slot_d;
            slot_gray_q <= slot_gray_d;
        end
    end

    assign slot      = slot_q;
    assign slot_gray = slot_gray_q;

endmodule

// File: rtl/tdm_link_scheduler.sv
// Packet-granular TDM arbiter for one NoC output link, with optional
// work-conserving round-robin fallback when the slot owner is idle.
module tdm_link_scheduler
    import tdm_link_scheduler_pkg::*;
#(
    parameter int  N_REQ           = 4,
    parameter int  SLOT_LEN        = 4,
    parameter int  MAX_PKT         = 64,
    parameter bit  WORK_CONSERVING = 1'b1,
    localparam int SW              = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             tx_valid,
    input  logic             tx_ready,
    input  logic             tx_last,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic [SW-1:0]    slot_gray,
    output logic             err_timeout
);

    localparam int HW = $clog2(MAX_PKT);

    logic [SW-1:0]    slot;
    logic [N_REQ-1:0] rot_req;
    logic             pick_valid;
    logic [SW-1:0]    pick_off;
    logic [SW-1:0]    pick_idx;
    logic             tail_hs;

    sched_state_t     state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             err_q, err_d;

    tdm_slot_timer #(
        .N_REQ    (N_REQ),
        .SLOT_LEN (SLOT_LEN),
        .SW       (SW)
    ) u_slot_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .slot      (slot),
        .slot_gray (slot_gray)
    );

    // Requests rotated so bit 0 is the current owner and bit k is owner+k.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot_req[gi] = req[slot + SW'(gi)];
        end
    endgenerate

    // Owner first; otherwise the nearest requester after it, scanning upward.
    always_comb begin
        pick_valid = rot_req[0];
        pick_off   = '0;
        if (!rot_req[0] && WORK_CONSERVING) begin
            for (int k = N_REQ - 1; k >= 1; k--) begin
                if (rot_req[k]) begin
                    pick_valid = 1'b1;
                    pick_off   = SW'(k);
                end
            end
        end
        pick_idx = slot + pick_off;
    end

    assign tail_hs = tx_valid & tx_ready & tx_last;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && pick_valid) begin
                    state_d = ST_BUSY;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            ST_BUSY: begin
                hold_d = hold_q + HW'(1);
                // Tail handshake takes priority over a coincident timeout.
                if (tail_hs) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (hold_q == HW'(MAX_PKT - 1)) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign gnt         = gnt_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_tdm_link_scheduler.sv
// Directed bench: a work-conserving and a strict-TDM scheduler share stimulus,
// with N_REQ=4, SLOT_LEN=4, MAX_PKT=8.
module tb_tdm_link_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       tx_valid, tx_ready, tx_last;

    logic [3:0] gnt, gnt_s;
    logic       busy, busy_s;
    logic [1:0] gray, gray_s;
    logic       err, err_s;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_timer;
    int m_slot;
    logic [1:0] gray_tab [4];

    tdm_link_scheduler #(
        .N_REQ(4), .SLOT_LEN(4), .MAX_PKT(8), .WORK_CONSERVING(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .gnt(gnt), .busy(busy), .slot_gray(gray), .err_timeout(err)
    );

    tdm_link_scheduler #(
        .N_REQ(4), .SLOT_LEN(4), .MAX_PKT(8), .WORK_CONSERVING(1'b0)
    ) dut_strict (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .gnt(gnt_s), .busy(busy_s), .slot_gray(gray_s), .err_timeout(err_s)
    );

    always #5 clk = ~clk;

    // Advance one clock and track the expected slot/timer from the en seen at that edge.
    task automatic step();
        logic en_s;
        en_s = en;
        @(posedge clk);
        #1;
        if (en_s) begin
            if (m_timer == 3) begin
                m_timer = 0;
                m_slot  = (m_slot + 1) % 4;
            end else begin
                m_timer = m_timer + 1;
            end
        end
    endtask

    task automatic set_tx(input logic v, input logic r, input logic l);
        tx_valid = v;
        tx_ready = r;
        tx_last  = l;
    endtask

    task automatic wait_slot(input int s);
        int guard;
        guard = 0;
        while (!(m_slot == s && m_timer == 0) && guard < 64) begin
            step();
            guard++;
        end
        n_cmp++;
        if (guard >= 64) begin
            n_fail++;
            $display("FAIL wait_slot timeout slot=%0d expected slot=%0d", m_slot, s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b1;
        req = 4'b0000;
        set_tx(1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt gnt=%b expected=0000", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy busy=%b expected=0", busy); end
        n_cmp++; if (gray !== 2'b00) begin n_fail++; $display("FAIL reset_gray gray=%b expected=00", gray); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err err=%b expected=0", err); end
        n_cmp++; if (gnt_s !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt_strict gnt=%b expected=0000", gnt_s); end
        n_cmp++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL reset_busy_strict busy=%b expected=0", busy_s); end
        rst     = 1'b1;
        m_timer = 0;
        m_slot  = 0;
        $display("test_reset: done");
    endtask

    task automatic test_slot_rotation();
        for (int i = 0; i < 32; i++) begin
            step();
            n_cmp++;
            if (gray !== gray_tab[m_slot]) begin
                n_fail++;
                $display("FAIL slot_gray cycle=%0d gray=%b expected=%b", i, gray, gray_tab[m_slot]);
            end
            n_cmp++;
            if (gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL rotation_gnt cycle=%0d gnt=%b expected=0000", i, gnt);
            end
        end
        $display("test_slot_rotation: 32 cycles, final slot=%0d", m_slot);
    endtask

    task automatic test_grant_owner();
        wait_slot(2);
        req = 4'b0100;
        step();
        n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL owner_grant gnt=%b expected=0100", gnt); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL owner_busy busy=%b expected=1", busy); end
        set_tx(1'b1, 1'b1, 1'b0);
        for (int f = 0; f < 4; f++) begin
            step();
            n_cmp++;
            if (gnt !== 4'b0100) begin n_fail++; $display("FAIL owner_hold flit=%0d gnt=%b expected=0100", f, gnt); end
        end
        tx_last = 1'b1;
        step();
        set_tx(1'b0, 1'b0, 1'b0);
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL tail_release gnt=%b expected=0000", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tail_busy busy=%b expected=0", busy); end
        step();
        n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL regrant gnt=%b expected=0100", gnt); end
        req = 4'b0000;
        set_tx(1'b1, 1'b1, 1'b1);
        step();
        set_tx(1'b0, 1'b0, 1'b0);
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL regrant_release gnt=%b expected=0000", gnt); end
        $display("test_grant_owner: packet of 5 flits to requester 2, then one regrant");
    endtask

    task automatic test_work_conserving();
        wait_slot(0);
        req = 4'b1010;
        step();
        n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL wc_grant gnt=%b expected=0010", gnt); end
        n_cmp++; if (gnt_s !== 4'b0000) begin n_fail++; $display("FAIL strict_wait gnt=%b expected=0000", gnt_s); end
        // Three more edges with slot 0 sampled (the last one advances slot to 1).
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (gnt_s !== 4'b0000) begin n_fail++; $display("FAIL strict_hold i=%0d gnt=%b expected=0000", i, gnt_s); end
            n_cmp++;
            if (gnt !== 4'b0010) begin n_fail++; $display("FAIL wc_hold i=%0d gnt=%b expected=0010", i, gnt); end
        end
        step();
        n_cmp++; if (gnt_s !== 4'b0010) begin n_fail++; $display("FAIL strict_grant gnt=%b expected=0010", gnt_s); end
        n_cmp++; if (busy_s !== 1'b1) begin n_fail++; $display("FAIL strict_busy busy=%b expected=1", busy_s); end
        req = 4'b0000;
        set_tx(1'b1, 1'b1, 1'b1);
        step();
        set_tx(1'b0, 1'b0, 1'b0);
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL wc_release gnt=%b expected=0000", gnt); end
        n_cmp++; if (gnt_s !== 4'b0000) begin n_fail++; $display("FAIL strict_release gnt=%b expected=0000", gnt_s); end
        $display("test_work_conserving: wc granted at slot 0, strict waited for slot 1");
    endtask

    task automatic test_timeout();
        req = 4'b0001;
        step();
        req = 4'b0000;
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL to_grant gnt=%b expected=0001", gnt); end
        for (int k = 1; k < 8; k++) begin
            step();
            n_cmp++;
            if (gnt !== 4'b0001 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL to_hold k=%0d gnt=%b err=%b expected gnt=0001 err=0", k, gnt, err);
            end
        end
        step();
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL to_release gnt=%b expected=0000", gnt); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err err=%b expected=1", err); end
        step();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse err=%b expected=0", err); end
        $display("test_timeout: forced release after 8 cycles");

        req = 4'b0001;
        step();
        req = 4'b0000;
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL to2_grant gnt=%b expected=0001", gnt); end
        for (int k = 1; k < 8; k++) step();
        set_tx(1'b1, 1'b1, 1'b1);
        step();
        set_tx(1'b0, 1'b0, 1'b0);
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL to2_release gnt=%b expected=0000", gnt); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL to2_err err=%b expected=0", err); end
        $display("test_timeout: tail on timeout cycle, no error pulse");
    endtask

    task automatic test_enable();
        logic [1:0] saved;
        int owner;
        req = 4'b0100;
        step();
        n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL en_grant gnt=%b expected=0100", gnt); end
        en    = 1'b0;
        req   = 4'b1111;
        saved = gray_tab[m_slot];
        set_tx(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (gnt !== 4'b0100) begin n_fail++; $display("FAIL en_hold i=%0d gnt=%b expected=0100", i, gnt); end
        end
        tx_last = 1'b1;
        step();
        set_tx(1'b0, 1'b0, 1'b0);
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL en_complete gnt=%b expected=0000", gnt); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (gnt !== 4'b0000) begin n_fail++; $display("FAIL en_blocked i=%0d gnt=%b expected=0000", i, gnt); end
            n_cmp++;
            if (gray !== saved) begin n_fail++; $display("FAIL en_frozen i=%0d gray=%b expected=%b", i, gray, saved); end
        end
        owner = m_slot;
        en    = 1'b1;
        step();
        n_cmp++;
        if (gnt !== (4'b0001 << owner)) begin
            n_fail++;
            $display("FAIL en_resume gnt=%b expected=%b", gnt, 4'b0001 << owner);
        end
        req = 4'b0000;
        set_tx(1'b1, 1'b1, 1'b1);
        step();
        set_tx(1'b0, 1'b0, 1'b0);
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL en_final gnt=%b expected=0000", gnt); end
        $display("test_enable: frozen with en=0, owner %0d granted on resume", owner);
    endtask

    task automatic test_async_reset();
        wait_slot(1);
        req = 4'b0001;
        step();
        req = 4'b0000;
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL ar_grant gnt=%b expected=0001", gnt); end
        n_cmp++; if (gray !== 2'b01) begin n_fail++; $display("FAIL ar_pre_gray gray=%b expected=01", gray); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL ar_gnt gnt=%b expected=0000", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy busy=%b expected=0", busy); end
        n_cmp++; if (gray !== 2'b00) begin n_fail++; $display("FAIL ar_gray gray=%b expected=00", gray); end
        @(posedge clk);
        #1;
        rst     = 1'b1;
        m_timer = 0;
        m_slot  = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (gray !== gray_tab[m_slot] || gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL ar_after i=%0d gray=%b gnt=%b expected gray=%b gnt=0000", i, gray, gnt, gray_tab[m_slot]);
            end
        end
        $display("test_async_reset: cleared between edges");
    endtask

    initial begin
        gray_tab[0] = 2'b00;
        gray_tab[1] = 2'b01;
        gray_tab[2] = 2'b11;
        gray_tab[3] = 2'b10;
        m_timer = 0;
        m_slot  = 0;
        test_reset();
        test_slot_rotation();
        test_grant_owner();
        test_work_conserving();
        test_timeout();
        test_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tdm_link_scheduler.md
# tdm_link_scheduler

Time-division scheduler that shares one NoC output link between N_REQ requesters at packet granularity. A slot counter rotates link ownership every SLOT_LEN cycles and exports the current slot index in Gray code for downstream consumers. Grants are held for a whole packet. When the slot owner has nothing to send, an optional work-conserving round-robin hands the link to another requester. The block sits between the router input ports and the output-link mux, and drives the mux select (gnt).

## Interface
- N_REQ, 4: number of requesters; power of two, 2..16
- SLOT_LEN, 4: cycles per TDM slot, ≥2
- MAX_PKT, 64: cycles a grant may be held before a forced release, ≥2
- WORK_CONSERVING, 1: 1 = idle-slot fallback to round-robin; 0 = strict TDM
- SW, $clog2(N_REQ): slot index width (derived; not user-set)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  scheduler enable; low freezes the slot timer and blocks new grants
- req  in  N_REQ  per-requester packet request; held high until its packet is granted
- tx_valid  in  1  flit valid on the muxed link
- tx_ready  in  1  link accepts flit
- tx_last  in  1  current flit is the tail of the packet
- gnt  out  N_REQ  one-hot grant, registered; zero when no grant
- busy  out  1  a grant is active (state BUSY)
- slot_gray  out  SW  current slot index in Gray code: slot ^ (slot >> 1)
- err_timeout  out  1  one-cycle pulse on a forced release

## Operation
- Reset values: gnt=0, busy=0, slot=0, slot_gray=0, timer=0, err_timeout=0, state IDLE.
- Slot timer: counts 0..SLOT_LEN-1 while en=1. At SLOT_LEN-1 it wraps to 0 and slot increments mod N_REQ (N_REQ-1 → 0). en=0 holds both timer and slot.
- The owner is the requester whose index equals slot.
- The slot timer never preempts an active grant. Slot rotation continues while in BUSY.
- FSM, two states:
  - IDLE: if en=0 or req=0, stay in IDLE.
    - If req[owner]=1, grant owner.
    - Otherwise, if WORK_CONSERVING=1, grant the first set req scanning owner+1, owner+2, … mod N_REQ.
    - Otherwise (strict TDM), no grant.
    - Granting sets gnt, clears the hold counter and moves to BUSY.
  - BUSY: the hold counter increments every cycle.
    - On tx_valid & tx_ready & tx_last: clear gnt and go to IDLE.
    - Otherwise, if the hold counter reaches MAX_PKT-1: clear gnt, pulse err_timeout and go to IDLE.
    - If both conditions hit in the same cycle, the tail handshake wins and err_timeout stays 0.
- en falling while BUSY: the packet completes normally. No new grant is issued until en=1.
- A requester dropping req while granted has no effect. Release happens only on tail handshake or timeout.
- Simultaneous slot advance and grant decision: the decision uses the owner value registered before the advance, i.e. the current slot.
- Asynchronous reset mid-packet: gnt clears immediately; the state returns to IDLE, slot to 0 and timer to 0.

## Timing
- Grant latency: req sampled in IDLE at cycle t produces gnt and busy at t+1.
- Release: tail handshake at cycle t gives gnt=0 and busy=0 at t+1. The earliest next grant is t+2, so there is one mandatory idle cycle.
- Timeout: gnt is first high at cycle g. With no tail handshake, gnt drops at g+MAX_PKT and err_timeout is high for that single cycle.
- slot_gray changes exactly one bit per slot advance, including the wrap from N_REQ-1 to 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package: FSM state encoding (IDLE, BUSY) and a bin2gray function reused by other Gray-coded counters in the NoC.
- Natural sub-module: tdm_slot_timer. It contains the timer and slot counter with en, and outputs slot and slot_gray.
- The FSM, round-robin search, hold counter and grant register live in tdm_link_scheduler itself.

## Test plan
- Reset with N_REQ=4, SLOT_LEN=4 and en=1 held for 32 cycles → slot_gray follows 0,1,3,2,0… and changes every 4 cycles. gnt=0 throughout.
- req=4'b0100 while slot=2 → gnt=4'b0100 one cycle later. Tail handshake after 5 flits → gnt=0 next cycle; no regrant for 1 cycle.
- WORK_CONSERVING=1, slot=0, req=4'b1010 → gnt=4'b0010. With WORK_CONSERVING=0 under the same stimulus → gnt stays 0 until slot=1, then gnt=4'b0010.
- Grant held with no tail, MAX_PKT=8 → gnt drops 8 cycles after assertion with a single-cycle err_timeout. Repeat with tx_last handshake landing on that same cycle → err_timeout=0.
- en deasserted mid-packet → packet completes, slot_gray frozen, no new grant despite req=4'b1111. en reasserted → grant 1 cycle later to the owner.
- rst asserted asynchronously mid-packet (between clock edges) → gnt=0, busy=0, slot_gray=0 immediately, with no clock edge needed.
